// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : window3x3_gen
// Description : Streams 3-pixel columns in and emits one 3x3 window per pixel,
//               with per-frame constant-pad or edge-replicate border taps.
// Revision    : 1.0  initial release
// ============================================================================
module window3x3_gen #(
  parameter int            DW        = 8,
  parameter int            COLS      = 400,
  parameter int            ROWS      = 400,
  parameter logic [DW-1:0] PAD_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3*DW-1:0] col_i,
  input  logic            valid_i,
  input  logic            sof_i,
  output logic            ready_o,
  input  logic            border_mode_i,
  output logic [9*DW-1:0] win_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            sof_o,
  output logic            eol_o,
  output logic            eof_o
);

  localparam int              c_CW       = $clog2(COLS);
  localparam int              c_RW       = $clog2(ROWS);
  localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(COLS - 1);
  localparam logic [c_CW-1:0] c_PEN_COL  = c_CW'(COLS - 2);
  localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3*DW-1:0] r_prev;
  logic [3*DW-1:0] r_cur;
  logic [c_CW-1:0] r_in_col;
  logic [c_RW-1:0] r_in_row;
  logic [c_CW-1:0] r_out_col;
  logic [c_RW-1:0] r_out_row;
  logic            r_mode;

  logic            w_slot_free;
  logic            w_accept;
  logic            w_sof_load;
  logic            w_load;
  logic            w_last_in;
  logic            w_top_inv;
  logic            w_bot_inv;
  logic            w_left_inv;
  logic            w_right_inv;
  logic [9*DW-1:0] w_win;
  logic [3*DW-1:0] w_colw [3];
  logic [DW-1:0]   w_pix  [3][3];

  assign w_slot_free = ~valid_o | ready_i;
  assign ready_o     = (r_state != ST_FLUSH) & w_slot_free;
  assign w_accept    = valid_i & ready_o;
  assign w_sof_load  = w_accept & sof_i;
  assign w_last_in   = (r_in_row == c_LAST_ROW) && (r_in_col == c_PEN_COL);
  assign w_load      = ((r_state == ST_RUN) & w_accept & ~sof_i) |
                       ((r_state == ST_FLUSH) & w_slot_free);

  assign w_top_inv   = (r_out_row == '0);
  assign w_bot_inv   = (r_out_row == c_LAST_ROW);
  assign w_left_inv  = (r_out_col == '0);
  assign w_right_inv = (r_out_col == c_LAST_COL);

  // The live input column serves as the right-hand stage; in FLUSH it is
  // always masked, so its content there is irrelevant.
  assign w_colw[0] = r_prev;
  assign w_colw[1] = r_cur;
  assign w_colw[2] = col_i;

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_col
      logic w_rinv;
      logic w_cinv;
      logic [DW-1:0] w_rep;

      assign w_pix[gi][gj] = w_colw[gj][DW*(2-gi) +: DW];
      assign w_rinv = (gi == 0) ? w_top_inv  : ((gi == 2) ? w_bot_inv   : 1'b0);
      assign w_cinv = (gj == 0) ? w_left_inv : ((gj == 2) ? w_right_inv : 1'b0);
      assign w_rep  = w_rinv ? (w_cinv ? w_pix[1][1] : w_pix[1][gj]) : w_pix[gi][1];
      assign w_win[DW*(3*gi+gj) +: DW] =
        (w_rinv | w_cinv) ? (r_mode ? w_rep : PAD_VALUE) : w_pix[gi][gj];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PRIME: if (w_sof_load) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && !sof_i && w_last_in) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_slot_free) w_state_nxt = ST_PRIME;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_PRIME;
      r_prev    <= '0;
      r_cur     <= '0;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_mode    <= 1'b0;
      win_o     <= '0;
      valid_o   <= 1'b0;
      sof_o     <= 1'b0;
      eol_o     <= 1'b0;
      eof_o     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_prev <= r_cur;
        r_cur  <= col_i;
      end

      // A frame start (also an abort in RUN) restarts every counter.
      if (w_sof_load) begin
        r_in_col  <= '0;
        r_in_row  <= '0;
        r_out_col <= '0;
        r_out_row <= '0;
        r_mode    <= border_mode_i;
      end else begin
        if (w_accept) begin
          if (r_in_col == c_LAST_COL) begin
            r_in_col <= '0;
            r_in_row <= (r_in_row == c_LAST_ROW) ? '0 : r_in_row + c_RW'(1);
          end else begin
            r_in_col <= r_in_col + c_CW'(1);
          end
        end
        if (w_load) begin
          if (r_out_col == c_LAST_COL) begin
            r_out_col <= '0;
            r_out_row <= (r_out_row == c_LAST_ROW) ? '0 : r_out_row + c_RW'(1);
          end else begin
            r_out_col <= r_out_col + c_CW'(1);
          end
        end
      end

      if (w_load) begin
        win_o   <= w_win;
        valid_o <= 1'b1;
        sof_o   <= w_top_inv & w_left_inv;
        eol_o   <= w_right_inv;
        eof_o   <= w_bot_inv & w_right_inv;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Parametrised 3x3 neighbourhood generator that sits between the line-buffer stage and the filter kernels.
- Accepts one 3-pixel image column per beat and emits one 3x3 window per pixel, centred on that pixel.
- Supports frame-synchronised streaming with valid/ready handshakes on both sides.
- Border taps are zero/constant-padded or edge-replicated, selected per frame; a flush state emits the final pixel's window.

Parameters:
DW, 8, pixel width in bits
COLS, 400, image width in pixels (>=2)
ROWS, 400, image height in pixels (>=2)
PAD_VALUE, 0, DW-bit value for out-of-image taps in constant mode

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
col_i  in  3*DW  input column: [3DW-1:2DW]=row r-1, [2DW-1:DW]=row r, [DW-1:0]=row r+1, all at column c
valid_i  in  1  col_i valid
sof_i  in  1  qualifies first column of a frame (valid only with valid_i)
ready_o  out  1  block accepts col_i this cycle
border_mode_i  in  1  0=constant PAD_VALUE, 1=replicate edge; sampled on accepted sof_i
win_o  out  9*DW  window; tap k at [DW*k +: DW], k=0..8 row-major, k=0 top-left, k=4 centre
valid_o  out  1  win_o valid
ready_i  in  1  downstream accepts win_o
sof_o  out  1  with valid_o: window centre is (0,0)
eol_o  out  1  with valid_o: centre column is COLS-1
eof_o  out  1  with valid_o: centre is (ROWS-1,COLS-1)

Behaviour:
- Reset values: win_o=0, valid_o=0, sof_o=eol_o=eof_o=0, all counters=0, FSM=PRIME, latched mode=0. ready_o=1 after reset.
- Accept = valid_i & ready_o. ready_o = (state!=FLUSH) & (~valid_o | ready_i).
- Output handshake: win_o and flags are held stable while valid_o & ~ready_i.
- Column shift register (L,C,R, each 3 pixels) shifts on accept: L<=C, C<=R, R<=col_i.
- Input column/row counters advance on accept and wrap at COLS-1/ROWS-1. Columns stream contiguously across rows with no gaps.
- FSM states: PRIME, RUN, FLUSH.
  - PRIME: waits for an accepted sof_i column. Columns without sof_i are discarded (accepted, not used).
  - First accept with sof_i: loads R, zeroes the input counters, latches border_mode_i, goes to RUN. No output.
  - RUN: each accept produces a window centred on the previous column (now in C). valid_o rises the cycle after the accept, so latency is 1 cycle from the accept of column c+1 to the window for column c.
  - The window for the last column of a row is produced when the next row's column 0 is accepted. The cross-row right neighbour is masked as border.
  - Accept of input (ROWS-1,COLS-1) -> FLUSH.
  - FLUSH: ready_o=0. Once the output slot is free, emits the final window (centre = last pixel, right taps masked) with eof_o=1, then returns to PRIME.
- Output centre counters (out_row, out_col) track the window centre, advance when a window is loaded, and drive sof_o/eol_o/eof_o.
- Border masking is decided from out_row/out_col:
  - Top row invalid when out_row==0; bottom row invalid when out_row==ROWS-1.
  - Left column invalid when out_col==0; right column invalid when out_col==COLS-1.
- Mode 0: every invalid tap = PAD_VALUE.
- Mode 1: an invalid row takes the centre-row value of the same column; an invalid column takes the centre-column value of the same row. Corners take the centre pixel (k=4).
- An accepted sof_i while in RUN aborts the current frame:
  - Any pending window already in the output slot completes normally; no window is generated for the aborted partial column.
  - Restarts as a PRIME->RUN load of the new column, with the new mode latched.
- sof_i while in FLUSH is not possible, because ready_o=0.
- rst at any time returns all state to reset values within one edge; a partially delivered frame is dropped.
- Counter width = $clog2(COLS) or $clog2(ROWS). No arithmetic on pixel data; pure selection.

Test Plan:
- COLS=4, ROWS=3, mode 0, PAD_VALUE=0, pixel(r,c)=16r+c, ready_i=1, back-to-back input:
  - 12 windows emitted.
  - First window: taps 0,0,0,0,0x00,0x01,0,0x10,0x11 with sof_o=1.
  - Last window has eof_o=1 and centre 0x23.
  - eol_o set on windows 4, 8 and 12.
- Same frame, mode 1:
  - Window (0,0) = 00,00,01,00,00,01,10,10,11.
  - Window (2,3) = 12,13,13,22,23,23,22,23,23.
- PAD_VALUE=0xFF, mode 0: every out-of-image tap on all 12 windows reads 0xFF.
- ready_i held low 5 cycles mid-frame:
  - ready_o drops the cycle after valid_o is set.
  - win_o is stable for those cycles; no window is lost or duplicated.
  - The totals and values match the unstalled run.
- sof_i reasserted at input column 6 of frame 1:
  - Pending window completes.
  - The next window output is (0,0) of the new frame with sof_o=1.
  - No eof_o is emitted for the aborted frame.
- rst pulsed one cycle during FLUSH:
  - valid_o=0 next cycle; the eof window is never emitted; ready_o=1.
  - The next frame starts cleanly with sof_o on its first window.
